// File: rtl/chess_pkg.sv
// Shared chess encodings, priority tables and sweep carry bundle.
package chess_pkg;

  localparam logic [2:0] PAWN   = 3'd0;
  localparam logic [2:0] KNIGHT = 3'd1;
  localparam logic [2:0] BISHOP = 3'd2;
  localparam logic [2:0] ROOK   = 3'd3;
  localparam logic [2:0] QUEEN  = 3'd4;
  localparam logic [2:0] KING   = 3'd5;
  localparam logic [2:0] EMPTY  = 3'd7;

  localparam logic COLOR_US   = 1'b0;
  localparam logic COLOR_THEM = 1'b1;

  localparam logic OP_VICTIM    = 1'b0;
  localparam logic OP_AGGRESSOR = 1'b1;

  typedef logic [3:0] piece_t;
  typedef logic [2:0] prio_t;

  // Per-file vectors leaving a rank. kn2/dp2 carry the previous rank's
  // knight and double-push emits so the next rank sees two ranks back.
  typedef struct packed {
    logic [7:0] str;
    logic [7:0] nw;
    logic [7:0] ne;
    logic [7:0] king;
    logic [7:0] push;
    logic [7:0] pcap;
    logic [7:0] kn1;
    logic [7:0] kn2;
    logic [7:0] dp1;
    logic [7:0] dp2;
  } carry_t;

  typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} state_t;

  function automatic prio_t victim_prio(input logic [2:0] typ);
    case (typ)
      QUEEN:   return 3'd6;
      ROOK:    return 3'd5;
      BISHOP:  return 3'd4;
      KNIGHT:  return 3'd3;
      PAWN:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic prio_t aggressor_prio(input logic [2:0] typ);
    case (typ)
      PAWN:    return 3'd6;
      KNIGHT:  return 3'd5;
      BISHOP:  return 3'd4;
      ROOK:    return 3'd3;
      QUEEN:   return 3'd2;
      KING:    return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/sweep_rank.sv
// One rank of the attack sweep: carries in, carries out, per-square priority.
module sweep_rank
  import chess_pkg::*;
(
  input  logic [2:0]  rank,
  input  logic [31:0] row,
  input  logic [7:0]  en,
  input  logic        op,
  input  logic [5:0]  tx_sq,
  input  carry_t      cin,
  output carry_t      cout,
  output prio_t [7:0] prio,
  output logic        illegal
);

  logic [7:0] is_tx;
  logic [7:0] e_str, e_diag, e_king, e_pawn, e_kn, pass;
  logic [7:0] nw_in, ne_in, king_in, kh_in, pcap_in, push_in, kn_in, east_in;
  logic [7:0] hit_str, hit_diag, hit_king, att;

  assign is_tx = (op == OP_AGGRESSOR && tx_sq[5:3] == rank) ? (8'b1 << tx_sq[2:0]) : 8'b0;

  // Decode which move kinds each square transmits and which squares let rays through
  always_comb begin
    e_str  = is_tx;
    e_diag = is_tx;
    e_king = is_tx;
    e_pawn = is_tx;
    e_kn   = is_tx;
    pass   = '0;
    for (int f = 0; f < 8; f++) begin
      if (op == OP_VICTIM && row[4*f+3] == COLOR_US) begin
        case (row[4*f +: 3])
          PAWN:    e_pawn[f] = 1'b1;
          KNIGHT:  e_kn[f]   = 1'b1;
          BISHOP:  e_diag[f] = 1'b1;
          ROOK:    e_str[f]  = 1'b1;
          QUEEN: begin
            e_str[f]  = 1'b1;
            e_diag[f] = 1'b1;
          end
          KING:    e_king[f] = 1'b1;
          default: ;
        endcase
      end
      pass[f] = (row[4*f +: 3] == EMPTY) & ~is_tx[f];
    end
  end

  assign nw_in   = cin.nw >> 1;
  assign ne_in   = cin.ne << 1;
  assign king_in = cin.king | (cin.king << 1) | (cin.king >> 1);
  assign kh_in   = e_king << 1;
  assign pcap_in = (cin.pcap << 1) | (cin.pcap >> 1);
  assign push_in = cin.push | cin.dp2;
  assign kn_in   = (cin.kn1 << 2) | (cin.kn1 >> 2) | (cin.kn2 << 1) | (cin.kn2 >> 1);

  // Eastward ray ripples across the rank from file 0 upward
  always_comb begin : east_chain
    logic run;
    run     = 1'b0;
    east_in = '0;
    for (int f = 0; f < 8; f++) begin
      east_in[f] = run;
      run        = e_str[f] | (pass[f] & run);
    end
  end

  assign hit_str  = cin.str | east_in;
  assign hit_diag = nw_in | ne_in;
  assign hit_king = king_in | kh_in;
  assign att      = hit_str | hit_diag | hit_king | pcap_in | kn_in;

  // Build the carries handed to the rank above
  always_comb begin
    cout      = '0;
    cout.str  = e_str  | (pass & cin.str);
    cout.nw   = e_diag | (pass & nw_in);
    cout.ne   = e_diag | (pass & ne_in);
    cout.king = e_king;
    cout.push = e_pawn;
    cout.pcap = e_pawn;
    cout.kn1  = e_kn;
    cout.kn2  = cin.kn1;
    cout.dp1  = (rank == 3'd1) ? e_pawn : 8'b0;
    cout.dp2  = cin.dp1;
  end

  // Score every square of the rank and flag an attacked enemy king
  always_comb begin
    prio    = '0;
    illegal = 1'b0;
    for (int f = 0; f < 8; f++) begin
      if (en[f]) begin
        if (op == OP_VICTIM) begin
          if (row[4*f +: 3] == EMPTY) begin
            prio[f] = (att[f] | push_in[f]) ? 3'd1 : 3'd0;
          end else if (row[4*f+3] == COLOR_THEM && att[f]) begin
            prio[f] = victim_prio(row[4*f +: 3]);
            if (row[4*f +: 3] == KING) illegal = 1'b1;
          end
        end else if (row[4*f+3] == COLOR_US) begin
          case (row[4*f +: 3])
            PAWN:    if (pcap_in[f])                prio[f] = aggressor_prio(PAWN);
            KNIGHT:  if (kn_in[f])                  prio[f] = aggressor_prio(KNIGHT);
            BISHOP:  if (hit_diag[f])               prio[f] = aggressor_prio(BISHOP);
            ROOK:    if (hit_str[f])                prio[f] = aggressor_prio(ROOK);
            QUEEN:   if (hit_str[f] | hit_diag[f])  prio[f] = aggressor_prio(QUEEN);
            KING:    if (hit_king[f])               prio[f] = aggressor_prio(KING);
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/capture_sweep.sv
// Rank-serial attack sweep returning the best MVV/LVA square via valid/ready.
module capture_sweep
  import chess_pkg::*;
#(
  parameter int RANKS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic         start_op,
  input  logic [5:0]   start_sq,
  input  logic [255:0] board,
  input  logic [63:0]  enable,
  output logic         busy,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [2:0]   res_prio,
  output logic [5:0]   res_sq,
  output logic         res_none,
  output logic         res_illegal
);

  localparam logic [2:0] LAST_BASE = 3'(8 - RANKS_PER_CYCLE);
  localparam logic [2:0] STEP      = 3'(RANKS_PER_CYCLE);

  state_t     state, state_nxt;
  logic [2:0] base;
  logic       op_q;
  logic [5:0] sq_q;
  carry_t     carry_q;
  prio_t      best_prio;
  logic [5:0] best_sq;
  logic       illegal_q;

  carry_t                      chain     [RANKS_PER_CYCLE+1];
  prio_t [7:0]                 rank_prio [RANKS_PER_CYCLE];
  logic [2:0]                  rank_idx  [RANKS_PER_CYCLE];
  logic [RANKS_PER_CYCLE-1:0]  rank_ill;

  prio_t      nb_prio;
  logic [5:0] nb_sq;
  logic       nb_ill;

  assign chain[0] = carry_q;

  for (genvar i = 0; i < RANKS_PER_CYCLE; i++) begin : g_rank
    assign rank_idx[i] = base + 3'(i);
    sweep_rank u_rank (
      .rank    (rank_idx[i]),
      .row     (board[{rank_idx[i], 5'd0} +: 32]),
      .en      (enable[{rank_idx[i], 3'd0} +: 8]),
      .op      (op_q),
      .tx_sq   (sq_q),
      .cin     (chain[i]),
      .cout    (chain[i+1]),
      .prio    (rank_prio[i]),
      .illegal (rank_ill[i])
    );
  end

  // Fold this cycle's ranks into the running best, scanning rank then file ascending
  always_comb begin
    nb_prio = best_prio;
    nb_sq   = best_sq;
    nb_ill  = illegal_q;
    for (int i = 0; i < RANKS_PER_CYCLE; i++) begin
      for (int f = 0; f < 8; f++) begin
        if (rank_prio[i][f] > nb_prio) begin
          nb_prio = rank_prio[i][f];
          nb_sq   = {rank_idx[i], 3'(f)};
        end
      end
      nb_ill = nb_ill | rank_ill[i];
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic for the command / sweep / result phases
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_valid)        state_nxt = ST_SWEEP;
      ST_SWEEP: if (base == LAST_BASE)  state_nxt = ST_DONE;
      ST_DONE:  if (res_ready)          state_nxt = ST_IDLE;
      default:                          state_nxt = ST_IDLE;
    endcase
  end

  // Latch the command, then accumulate carries and the best result each pass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base      <= '0;
      op_q      <= 1'b0;
      sq_q      <= '0;
      carry_q   <= '0;
      best_prio <= '0;
      best_sq   <= '0;
      illegal_q <= 1'b0;
    end else if (state == ST_IDLE && start_valid) begin
      base      <= '0;
      op_q      <= start_op;
      sq_q      <= start_sq;
      carry_q   <= '0;
      best_prio <= '0;
      best_sq   <= '0;
      illegal_q <= 1'b0;
    end else if (state == ST_SWEEP) begin
      base      <= base + STEP;
      carry_q   <= chain[RANKS_PER_CYCLE];
      best_prio <= nb_prio;
      best_sq   <= nb_sq;
      illegal_q <= nb_ill;
    end
  end

  assign start_ready = (state == ST_IDLE);
  assign busy        = (state == ST_SWEEP);
  assign res_valid   = (state == ST_DONE);
  assign res_prio    = best_prio;
  assign res_sq      = best_sq;
  assign res_none    = (best_prio == 3'd0);
  assign res_illegal = illegal_q;

endmodule

// File: tb/tb_capture_sweep.sv
// Randomised and directed check of capture_sweep at all four rank widths.
module tb_capture_sweep;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_op = 1'b0;
  logic [5:0]   start_sq = '0;
  logic [255:0] board = '1;
  logic [63:0]  enable = '1;
  logic         res_ready = 1'b0;

  logic [3:0] start_ready_v, busy_v, res_valid_v, res_none_v, res_illegal_v;
  logic [2:0] res_prio_v [4];
  logic [5:0] res_sq_v   [4];

  int checks = 0;
  int passed = 0;

  logic [255:0] m_brd;
  logic [63:0]  m_en;
  logic         m_op;
  logic [5:0]   m_tsq;
  bit           hit [6][64];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    capture_sweep #(.RANKS_PER_CYCLE(1 << g)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready_v[g]),
      .start_op    (start_op),
      .start_sq    (start_sq),
      .board       (board),
      .enable      (enable),
      .busy        (busy_v[g]),
      .res_valid   (res_valid_v[g]),
      .res_ready   (res_ready),
      .res_prio    (res_prio_v[g]),
      .res_sq      (res_sq_v[g]),
      .res_none    (res_none_v[g]),
      .res_illegal (res_illegal_v[g])
    );
  end

  task automatic checkOutput(input string tag, input int g, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed === expected) passed++;
    else $display("[TB] FAIL %s rpc=%0d observed=%0h expected=%0h", tag, 1 << g, observed, expected);
  endtask

  // Reference: kind 0 straight, 1 diagonal, 2 king, 3 pawn capture, 4 knight, 5 push
  function automatic void mark(input int r, input int f, input int k);
    if (r >= 0 && r < 8 && f >= 0 && f < 8) hit[k][r*8+f] = 1'b1;
  endfunction

  function automatic void ray(input int r, input int f, input int dr, input int df, input int k);
    int rr, ff, q;
    rr = r + dr;
    ff = f + df;
    while (rr >= 0 && rr < 8 && ff >= 0 && ff < 8) begin
      q = rr * 8 + ff;
      hit[k][q] = 1'b1;
      if (m_brd[4*q +: 3] != 3'd7 || (m_op && q == int'(m_tsq))) break;
      rr += dr;
      ff += df;
    end
  endfunction

  function automatic void ref_model(output logic [2:0] p, output logic [5:0] s, output logic ill);
    int r, f;
    logic [2:0] t, pq;
    logic c;
    bit es, ed, ek, ep, ekn, att;
    for (int k = 0; k < 6; k++)
      for (int q = 0; q < 64; q++) hit[k][q] = 1'b0;
    for (int src = 0; src < 64; src++) begin
      r = src / 8;
      f = src % 8;
      t = m_brd[4*src +: 3];
      c = m_brd[4*src+3];
      es = 0; ed = 0; ek = 0; ep = 0; ekn = 0;
      if (m_op) begin
        if (src == int'(m_tsq)) begin es = 1; ed = 1; ek = 1; ep = 1; ekn = 1; end
      end else if (c == 1'b0) begin
        case (t)
          3'd0: ep = 1;
          3'd1: ekn = 1;
          3'd2: ed = 1;
          3'd3: es = 1;
          3'd4: begin es = 1; ed = 1; end
          3'd5: ek = 1;
          default: ;
        endcase
      end
      if (es) begin ray(r, f, 1, 0, 0); ray(r, f, 0, 1, 0); end
      if (ed) begin ray(r, f, 1, 1, 1); ray(r, f, 1, -1, 1); end
      if (ek) begin mark(r+1, f-1, 2); mark(r+1, f, 2); mark(r+1, f+1, 2); mark(r, f+1, 2); end
      if (ep) begin
        mark(r+1, f-1, 3); mark(r+1, f+1, 3); mark(r+1, f, 5);
        if (r == 1) mark(r+2, f, 5);
      end
      if (ekn) begin mark(r+1, f-2, 4); mark(r+1, f+2, 4); mark(r+2, f-1, 4); mark(r+2, f+1, 4); end
    end
    p = 0; s = 0; ill = 0;
    for (int q = 0; q < 64; q++) begin
      if (!m_en[q]) continue;
      t   = m_brd[4*q +: 3];
      c   = m_brd[4*q+3];
      att = hit[0][q] | hit[1][q] | hit[2][q] | hit[3][q] | hit[4][q];
      pq  = 0;
      if (!m_op) begin
        if (t == 3'd7) pq = (att || hit[5][q]) ? 3'd1 : 3'd0;
        else if (c == 1'b1 && att) begin
          case (t)
            3'd4: pq = 6;  3'd3: pq = 5;  3'd2: pq = 4;
            3'd1: pq = 3;  3'd0: pq = 2;  default: pq = 0;
          endcase
          if (t == 3'd5) ill = 1;
        end
      end else if (t != 3'd7 && c == 1'b0) begin
        case (t)
          3'd0: if (hit[3][q]) pq = 6;
          3'd1: if (hit[4][q]) pq = 5;
          3'd2: if (hit[1][q]) pq = 4;
          3'd3: if (hit[0][q]) pq = 3;
          3'd4: if (hit[0][q] || hit[1][q]) pq = 2;
          3'd5: if (hit[2][q]) pq = 1;
          default: ;
        endcase
      end
      if (pq > p) begin p = pq; s = 6'(q); end
    end
  endfunction

  function automatic logic [255:0] put(input logic [255:0] b, input int sq, input logic [3:0] v);
    b[4*sq +: 4] = v;
    return b;
  endfunction

  // One full command: offer, wait for every instance, check, optional backpressure, consume
  task automatic applyStimulus(input logic op, input logic [5:0] sq, input logic [255:0] brd,
                               input logic [63:0] en, input int hold);
    logic [2:0] ep;
    logic [5:0] es;
    logic       ei;
    int         lat [4];
    m_op = op; m_tsq = sq; m_brd = brd; m_en = en;
    ref_model(ep, es, ei);
    @(negedge clk);
    board = brd; enable = en; start_op = op; start_sq = sq; start_valid = 1'b1;
    for (int g = 0; g < 4; g++) checkOutput("idle_ready", g, start_ready_v[g], 1);
    @(posedge clk);
    #1 start_valid = 1'b0;
    for (int g = 0; g < 4; g++) begin
      checkOutput("busy_after_accept", g, busy_v[g], 1);
      lat[g] = 0;
    end
    for (int c = 1; c <= 20 && res_valid_v != 4'hF; c++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 4; g++) if (res_valid_v[g] && lat[g] == 0) lat[g] = c;
    end
    for (int g = 0; g < 4; g++) begin
      checkOutput("latency", g, lat[g], 8 >> g);
      checkOutput("prio", g, res_prio_v[g], ep);
      checkOutput("sq", g, res_sq_v[g], es);
      checkOutput("none", g, res_none_v[g], ep == 0);
      checkOutput("illegal", g, res_illegal_v[g], ei);
    end
    if (hold > 0) begin
      start_valid = 1'b1;
      repeat (hold) @(posedge clk);
      #1;
      for (int g = 0; g < 4; g++) begin
        checkOutput("hold_valid", g, res_valid_v[g], 1);
        checkOutput("hold_start_ready", g, start_ready_v[g], 0);
        checkOutput("hold_prio", g, res_prio_v[g], ep);
        checkOutput("hold_sq", g, res_sq_v[g], es);
      end
    end
    @(negedge clk);
    start_valid = 1'b0;
    res_ready   = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    for (int g = 0; g < 4; g++) begin
      checkOutput("post_ready", g, start_ready_v[g], 1);
      checkOutput("post_valid", g, res_valid_v[g], 0);
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [255:0] b;
    logic [255:0] empty_b;
    logic [63:0]  e;
    logic [3:0]   seen;
    empty_b = {64{4'hF}};

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      checkOutput("rst_start_ready", g, start_ready_v[g], 1);
      checkOutput("rst_busy", g, busy_v[g], 0);
      checkOutput("rst_valid", g, res_valid_v[g], 0);
      checkOutput("rst_prio", g, res_prio_v[g], 0);
      checkOutput("rst_sq", g, res_sq_v[g], 0);
      checkOutput("rst_none", g, res_none_v[g], 1);
      checkOutput("rst_illegal", g, res_illegal_v[g], 0);
    end
    rst_n = 1'b1;

    $display("[TB] empty board");
    applyStimulus(1'b0, 6'd0, empty_b, '1, 0);

    $display("[TB] victim mixed targets");
    b = put(put(put(empty_b, 0, 4'h3), 56, 4'hC), 7, 4'hA);
    applyStimulus(1'b0, 6'd0, b, '1, 0);

    $display("[TB] aggressor");
    b = put(put(put(empty_b, 28, 4'h8), 45, 4'h1), 60, 4'h4);
    applyStimulus(1'b1, 6'd28, b, '1, 0);

    $display("[TB] tie");
    b = put(put(put(empty_b, 8, 4'h3), 9, 4'h9), 16, 4'h9);
    applyStimulus(1'b0, 6'd0, b, '1, 0);

    $display("[TB] illegal king");
    b = put(put(empty_b, 3, 4'h3), 59, 4'hD);
    applyStimulus(1'b0, 6'd0, b, '1, 0);
    e = '1;
    e[4] = 1'b0;
    applyStimulus(1'b0, 6'd0, b, e, 0);

    $display("[TB] backpressure");
    b = put(put(put(empty_b, 0, 4'h3), 56, 4'hC), 7, 4'hA);
    applyStimulus(1'b0, 6'd0, b, '1, 5);

    $display("[TB] reset mid sweep");
    @(negedge clk);
    board = empty_b; enable = '1; start_op = 1'b0; start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) checkOutput("pre_abort_valid", g, res_valid_v[g], 0);
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 4; g++) checkOutput("abort_valid", g, res_valid_v[g], 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = '0;
    repeat (12) begin
      @(posedge clk);
      #1 seen = seen | res_valid_v;
    end
    for (int g = 0; g < 4; g++) begin
      checkOutput("abort_no_result", g, seen[g], 0);
      checkOutput("abort_ready", g, start_ready_v[g], 1);
    end

    $display("[TB] random boards");
    for (int n = 0; n < 40; n++) begin
      for (int q = 0; q < 64; q++) begin
        if ($urandom_range(0, 99) < 55) b[4*q +: 4] = 4'hF;
        else b[4*q +: 4] = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 5))};
        e[q] = ($urandom_range(0, 9) != 0);
      end
      applyStimulus(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), b, e,
                    $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/capture_sweep.md
# capture_sweep

Parametrised attack-sweep engine for the chess move generator. It takes a board snapshot and a command (FIND-VICTIM or FIND-AGGRESSOR), propagates attacks rank by rank from rank 0 northward, and returns the single best square under MVV/LVA priority. A parameter sets how many ranks are processed per cycle, so the same block trades area for latency. Command and result use valid/ready handshakes instead of a fixed-latency pulse.

## Interface
- `RANKS_PER_CYCLE`, default 1: ranks evaluated per sweep cycle. Legal values are 1, 2, 4, 8. Passes per sweep `P = 8/RANKS_PER_CYCLE`.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start_valid` in 1: command offered.
- `start_ready` out 1: command accepted on `start_valid && start_ready`.
- `start_op` in 1: 0 = VICTIM, 1 = AGGRESSOR.
- `start_sq` in 6: transmitter square `{rank, file}`. Used in AGGRESSOR mode only.
- `board` in 256: nibble `4*sq` is `{color, type}`.
  - color: 0 = US, 1 = THEM.
  - type: PAWN 0, KNIGHT 1, BISHOP 2, ROOK 3, QUEEN 4, KING 5, EMPTY 7.
- `enable` in 64: per-square result enable.
- `busy` out 1: sweep in progress.
- `res_valid` out 1: result available.
- `res_ready` in 1: result consumed on `res_valid && res_ready`.
- `res_prio` out 3: winning priority.
- `res_sq` out 6: winning square.
- `res_none` out 1: `res_prio == 0`.
- `res_illegal` out 1: in VICTIM mode, an enabled THEM king is attacked.

## Operation
- **States:** IDLE, SWEEP, DONE. `start_ready = (state == IDLE)`, `busy = (state == SWEEP)`, `res_valid = (state == DONE)`.
- **IDLE → SWEEP** on start handshake.
  - Latch op and square.
  - Clear the rank counter, all carry registers, the best prio/sq and the illegal accumulator.
- **SWEEP:** each cycle, evaluate ranks `base .. base+RANKS_PER_CYCLE-1` combinationally, chained in-cycle.
  - Register the carries out of the top rank, plus the best prio/sq and the illegal flag.
  - Advance `base` by `RANKS_PER_CYCLE`.
  - After pass P, go to DONE.
- **DONE → IDLE** on result handshake. Outputs hold unchanged while `res_ready` is low. No new command is accepted in DONE.
- **Upstream obligation:** `board` and `enable` are held stable from the start handshake to the result handshake. The block does not snapshot them.
- **Transmitters per square:**
  - AGGRESSOR and the square equals the latched square: emits all move kinds.
  - VICTIM: emits only for US pieces, by type.
  - EMPTY squares pass straight/diagonal rays through. The transmitting square is never treated as empty.
- **Carries into rank r:**
  - south: from file f of r-1.
  - southeast: from f+1 of r-1.
  - southwest: from f-1 of r-1.
  - king: f-1, f, f+1 of r-1.
  - pawn push: f of r-1.
  - pawn capture: f±1 of r-1.
  - double push: f of r-2, sourced only from rank 1.
  - knight: f±2 of r-1, f±1 of r-2.
  - east ray and same-rank king: propagate from file f-1 within the rank.
- **Priority, VICTIM** (THEM piece attacked): Q 6, R 5, B 4, N 3, P 2; EMPTY attacked or reached by a push 1; else 0.
- **Priority, AGGRESSOR** (US piece reached by its own move kind): P 6, N 5, B 4, R 3, Q 2, K 1.
- Disabled squares give priority 0 and no illegal contribution.
- **Arbitration:** strict-greater replacement in scan order (rank ascending, file ascending). On a tie the lowest square wins. With no winner, `res_sq = 0`.

## Timing
- Start accepted at edge t; `res_valid` rises after edge t+P. Latency is 8, 4, 2, 1 cycles for `RANKS_PER_CYCLE` = 1, 2, 4, 8.
- Result handshake at edge u gives `start_ready = 1` after u. This is one bubble between back-to-back commands.
- **Reset values:** state IDLE, `start_ready` 1, `busy` 0, `res_valid` 0, `res_prio` 0, `res_sq` 0, `res_none` 1, `res_illegal` 0.
- **Reset mid-SWEEP or mid-DONE:** aborts immediately. No result is ever presented for the aborted command.
- `start_valid` while not in IDLE is ignored. The command is not queued.

## Structure
- **Shared package `chess_pkg`:**
  - piece type codes, color codes, op codes;
  - `piece_t` (4-bit) and `prio_t` (3-bit);
  - the VICTIM and AGGRESSOR priority tables as functions.
- **Sub-module `sweep_rank`:** combinational, one rank. It takes the carries in and produces the carries out, 8 priorities and an illegal bit. Instantiate it `RANKS_PER_CYCLE` times, muxed by `base`.
- The arbiter chain lives inline in `capture_sweep`.

## Test plan
1. **Empty board** (all nibbles 0xF), all enabled, VICTIM:
   - `res_valid` appears P cycles after accept;
   - prio 0, none 1, sq 0, illegal 0.
2. **VICTIM mixed targets:** US rook sq 0 (0x3), THEM queen sq 56 (0xC), THEM bishop sq 7 (0xA), rest empty → prio 6, sq 56.
3. **AGGRESSOR:** `start_sq` 28, THEM pawn sq 28, US knight sq 45, US queen sq 60, rest empty → prio 5, sq 45.
4. **Tie and illegal:**
   - US rook sq 8, THEM knights sq 9 and sq 16, VICTIM → prio 3, sq 9.
   - US rook sq 3, THEM king sq 59 → prio 1, sq 4, illegal 1.
   - Same as the line above with enable bit 4 cleared → sq 5.
5. **Backpressure and reset:**
   - `res_ready` low 5 cycles → outputs stable, `start_ready` 0.
   - `rst_n` low during pass 2 → `res_valid` never rises, `start_ready` 1 after release.
6. **Parameter sweep:** rerun 1–4 at `RANKS_PER_CYCLE` 1/2/4/8 → identical results, latency 8/4/2/1.
